// File: rtl/uart_rx_deserializer_pkg.sv
// Shared constants and the receiver state type for the UART receive path.
package UartPkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;
    localparam int unsigned TX_BITS   = DATA_BITS + STOP_BITS + 2;

    // Bit positions within Rx_Error
    localparam int unsigned ERR_BREAK  = 0;
    localparam int unsigned ERR_PARITY = 1;
    localparam int unsigned ERR_FRAME  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreakWait
    } rx_state_t;

endpackage

// File: rtl/uart_rx_deserializer_sampler.sv
// Bit-period timing for the receiver: sample counter plus optional 2-of-3 vote.
// Optional build macro: RX_MAJORITY_VOTE_EN.
module uart_rx_sampler #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic SysClk,
    input  logic Rst_n,
    input  logic rx,
    input  logic enable,
    input  logic clear,
    input  logic half,
    output logic bit_strobe,
    output logic bit_value
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] FullEnd = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);

`ifdef RX_MAJORITY_VOTE_EN
    // Decision lands one cycle after mid-bit, so the count is already one step in.
    localparam logic [CntW-1:0] Reload = CntW'(1);
`else
    localparam logic [CntW-1:0] Reload = '0;
`endif

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick;

    assign tick = enable && (cnt_q == (half ? HalfEnd : FullEnd));

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (!enable) begin
            cnt_d = '0;
        end else if (clear) begin
            cnt_d = bit_strobe ? Reload : '0;
        end else if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;
    logic       pend_q;

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            hist_q <= 2'b11;
            pend_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], rx};
            pend_q <= tick;
        end
    end

    assign bit_strobe = pend_q;
    assign bit_value  = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx) | (hist_q[0] & rx);
`else
    assign bit_strobe = tick;
    assign bit_value  = rx;
`endif

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: start detect, data/parity/stop capture, error flags, valid/ready out.
// Optional build macro: RX_MAJORITY_VOTE_EN (2-of-3 vote per bit, handled in the sampler).
module uart_rx_deserializer #(
    parameter int unsigned DATA_BITS    = UartPkg::DATA_BITS,
    parameter int unsigned STOP_BITS    = UartPkg::STOP_BITS,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                 SysClk,
    input  logic                 Rst_n,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Valid,
    input  logic                 Rx_Ready,
    output logic [2:0]           Rx_Error,
    output logic                 Overrun,
    output logic                 Rx_Busy
);

    import UartPkg::*;

    localparam int unsigned BitMax = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int unsigned BitW   = $clog2(BitMax + 1);

    rx_state_t            state_q, state_d;
    logic                 rx_q;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 any0_q, any0_d;
    logic                 all0_q, all0_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic [2:0]           err_q, err_d;
    logic                 ovr_q, ovr_d;

    logic bit_strobe, bit_value;
    logic samp_enable, samp_clear, samp_half;
    logic frame_err, stop_all0, brk, parity_err;

    uart_rx_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .SysClk    (SysClk),
        .Rst_n     (Rst_n),
        .rx        (Rx),
        .enable    (samp_enable),
        .clear     (samp_clear),
        .half      (samp_half),
        .bit_strobe(bit_strobe),
        .bit_value (bit_value)
    );

    assign samp_enable = (state_q != StIdle) && (state_q != StBreakWait);
    assign samp_half   = (state_q == StStart);
    assign samp_clear  = (state_d != state_q);

    // Frame status including the stop sample being taken right now
    assign frame_err  = any0_q | ~bit_value;
    assign stop_all0  = all0_q & ~bit_value;
    assign brk        = (shift_q == '0) && !par_q && stop_all0;
    assign parity_err = par_q ^ (^shift_q);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        any0_d    = any0_q;
        all0_d    = all0_q;
        data_d    = data_q;
        err_d     = err_q;
        ovr_d     = 1'b0;
        valid_d   = valid_q && !Rx_Ready;

        unique case (state_q)
            StIdle: begin
                if (rx_q && !Rx) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_strobe) begin
                    state_d = bit_value ? StIdle : StData;
                end
            end
            StData: begin
                if (bit_strobe) begin
                    shift_d   = {shift_q[DATA_BITS-2:0], bit_value};
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (bit_strobe) begin
                    par_d   = bit_value;
                    any0_d  = 1'b0;
                    all0_d  = 1'b1;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (bit_strobe) begin
                    any0_d    = frame_err;
                    all0_d    = stop_all0;
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == BitW'(STOP_BITS - 1)) begin
                        err_d             = '0;
                        err_d[ERR_BREAK]  = brk;
                        err_d[ERR_PARITY] = !brk && parity_err;
                        err_d[ERR_FRAME]  = !brk && frame_err;
                        state_d           = brk ? StBreakWait : StIdle;
                        if (!brk && !frame_err && !parity_err) begin
                            // A word being accepted this cycle frees the slot
                            if (!valid_q || Rx_Ready) begin
                                valid_d = 1'b1;
                                data_d  = shift_q;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end
                    end
                end
            end
            StBreakWait: begin
                if (Rx) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge SysClk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= StIdle;
            rx_q      <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            any0_q    <= 1'b0;
            all0_q    <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_q      <= Rx;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            any0_q    <= any0_d;
            all0_q    <= all0_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
        end
    end

    assign Rx_Data  = data_q;
    assign Rx_Valid = valid_q;
    assign Rx_Error = err_q;
    assign Overrun  = ovr_q;
    assign Rx_Busy  = (state_q != StIdle);

endmodule
